// File: rtl/svm_pkg.sv
// rtl/svm_pkg.sv - shared types, pipeline constants and sizing helper for the SVM classifier
package svm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Edges from accepting the final beat to oDone being sampled high
  localparam int PIPE_LAT = 4;

  // Ceiling log2, never below 1 so it can size a counter for a single-beat window
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/svm_adder_tree.sv
// rtl/svm_adder_tree.sv - registered sign-extending sum of LANES signed inputs with valid and flush
module svm_adder_tree
  import svm_pkg::*;
#(
  parameter int LANES = 2,
  parameter int IN_W  = 32,
  parameter int OUT_W = 48
) (
  input  logic                    iClk,
  input  logic                    iRst_n,
  input  logic                    in_valid,
  input  logic [LANES*IN_W-1:0]   in_data,
  input  logic                    flush,
  output logic                    out_valid,
  output logic [OUT_W-1:0]        out_sum
);

  logic signed [IN_W-1:0]  lane;
  logic signed [OUT_W-1:0] sum_c;

  always_comb begin
    lane  = '0;
    sum_c = '0;
    for (int i = 0; i < LANES; i++) begin
      lane  = $signed(in_data[i*IN_W +: IN_W]);
      sum_c = sum_c + OUT_W'(lane);
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else begin
      out_valid <= in_valid & ~flush;
      if (in_valid) out_sum <= sum_c;
    end
  end

endmodule

// File: rtl/svm_dot_classifier.sv
// rtl/svm_dot_classifier.sv - streaming linear-SVM dot product, bias and human/not-human decision
module svm_dot_classifier
  import svm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int LANES  = 2,
  parameter int N_FEAT = 3780,
  parameter int ACC_W  = 48
) (
  input  logic                      iClk,
  input  logic                      iRst_n,
  input  logic                      iStart,
  input  logic [ACC_W-1:0]          iBias,
  input  logic                      iValid,
  input  logic [LANES*DATA_W-1:0]   iFeat,
  input  logic [LANES*DATA_W-1:0]   iWeight,
  output logic                      oReady,
  output logic                      oBusy,
  output logic                      oDone,
  output logic                      oHuman,
  output logic [ACC_W-1:0]          oScore
);

  localparam int BEATS = N_FEAT / LANES;
  localparam int CNT_W = clog2(BEATS);
  localparam int PW    = 2 * DATA_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if (ACC_W < PW + clog2(N_FEAT)) begin : g_acc_w_check
    $error("ACC_W too narrow for the feature count");
  end
  if (FRAC_W >= DATA_W) begin : g_frac_w_check
    $error("FRAC_W must be smaller than DATA_W");
  end
  if (N_FEAT % LANES != 0) begin : g_lanes_check
    $error("N_FEAT must be a multiple of LANES");
  end

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc;
  logic [LANES*PW-1:0]     s1_prod;
  logic                    s1_valid;
  logic                    s2_valid;
  logic [ACC_W-1:0]        s2_sum;
  logic signed [PW-1:0]    prod_c [LANES];

  // A start is honoured only where a new window may begin; it also flushes in-flight beats
  logic restart;
  logic accept;
  assign restart = iStart & ((state == IDLE) | (state == ACCUM));
  assign accept  = iValid & oReady & ~iStart;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_c[i] = PW'($signed(iFeat[i*DATA_W +: DATA_W])) *
                  PW'($signed(iWeight[i*DATA_W +: DATA_W]));
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        for (int i = 0; i < LANES; i++) s1_prod[i*PW +: PW] <= prod_c[i];
      end
    end
  end

  svm_adder_tree #(
    .LANES (LANES),
    .IN_W  (PW),
    .OUT_W (ACC_W)
  ) u_tree (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .in_valid  (s1_valid),
    .in_data   (s1_prod),
    .flush     (restart),
    .out_valid (s2_valid),
    .out_sum   (s2_sum)
  );

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      acc <= '0;
    end else if (restart) begin
      acc <= $signed(iBias);
    end else if (s2_valid) begin
      acc <= acc + $signed(s2_sum);
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      oReady <= 1'b0;
      oBusy  <= 1'b0;
      oDone  <= 1'b0;
      oHuman <= 1'b0;
      oScore <= '0;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            state  <= ACCUM;
            cnt    <= '0;
            oReady <= 1'b1;
            oBusy  <= 1'b1;
          end
        end
        ACCUM: begin
          if (iStart) begin
            cnt <= '0;
          end else if (iValid) begin
            if (cnt == LAST_BEAT) begin
              state  <= DRAIN;
              oReady <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          // The accumulator is final once both upstream stages have emptied
          if (!s1_valid && !s2_valid) begin
            state  <= DONE;
            oBusy  <= 1'b0;
            oDone  <= 1'b1;
            oScore <= acc;
            oHuman <= ~acc[ACC_W-1];
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/svm_dot_classifier.md
Name: svm_dot_classifier

Overview:
- Parametrised linear-SVM decision block for the HOG human-detection pipeline.
- Streams HOG feature / trained-weight pairs, LANES pairs per beat, as signed fixed point.
- Pipelined multiply, adder tree and accumulate, plus bias; emits the raw score and a human / not-human decision per detection window.
- Sits between the HOG descriptor block and the window-result logic. Replaces the single-lane, clock-toggled float classifier with a fully synchronous, handshaked design.

Parameters:
- DATA_W, 16, width of each signed feature and weight (two's complement).
- FRAC_W, 8, fractional bits of DATA_W values; products carry 2*FRAC_W fractional bits.
- LANES, 2, feature/weight pairs per beat; power of two, at least 1.
- N_FEAT, 3780, features per window; must be a multiple of LANES.
- ACC_W, 48, accumulator and score width; must be at least 2*DATA_W + clog2(N_FEAT).

Ports:
- iClk  in  1  clock
- iRst_n  in  1  reset, synchronous, active-low
- iStart  in  1  one-cycle pulse; begins a window and latches iBias
- iBias  in  ACC_W  signed bias, 2*FRAC_W fractional bits
- iValid  in  1  beat valid
- iFeat  in  LANES*DATA_W  packed features; lane 0 in the LSBs
- iWeight  in  LANES*DATA_W  packed weights; lane 0 in the LSBs
- oReady  out  1  beat accepted on an edge where iValid & oReady
- oBusy  out  1  window in progress
- oDone  out  1  one-cycle pulse; result registers updated
- oHuman  out  1  1 when score >= 0
- oScore  out  ACC_W  signed score = sum(feat*weight) + bias

Behaviour:
- Reset (iRst_n=0 at an edge), regardless of state:
  - state=IDLE, beat counter=0, accumulator=0, pipeline valids cleared.
  - oReady=0, oBusy=0, oDone=0, oHuman=0, oScore=0.
- States: IDLE, ACCUM, DRAIN, DONE.
  - IDLE: oReady=0. iStart -> ACCUM; accumulator loaded with iBias; beat counter=0.
  - ACCUM: oReady=1.
    - Each accepted beat increments the counter; no stall penalty for iValid gaps.
    - Accepting beat N_FEAT/LANES-1 -> DRAIN, with oReady=0 from the next cycle.
  - DRAIN: oReady=0; waits until pipeline valids are empty -> DONE.
  - DONE: one cycle.
    - Registers oScore = accumulator and oHuman = ~accumulator[ACC_W-1].
    - oDone=1 for exactly this cycle; returns to IDLE.
- oBusy=1 in ACCUM and DRAIN.
- Pipeline, registered per stage:
  - S1: LANES signed products, 2*DATA_W bits each.
  - S2: adder-tree sum, sign-extended to ACC_W.
  - S3: accumulator += S2 sum.
- Latency: oDone is high on the 4th edge after the edge that accepts the final beat.
- oScore and oHuman hold their values until the next DONE or reset.
- Arithmetic:
  - Full-precision signed multiply; sign extension in the tree; no rounding.
  - ACC_W sizing guarantees no overflow. Wrap is acceptable only if the parameter constraint is violated.
- Ignored inputs:
  - iValid when oReady=0 (IDLE, DRAIN, DONE): ignored, no effect.
  - iStart in DRAIN or DONE: ignored.
- Restart and reset mid-window:
  - iStart in ACCUM aborts the window: counter=0, accumulator=iBias, in-flight S1/S2 valids flushed, no oDone for the aborted window.
  - If iStart and iValid arrive in the same ACCUM cycle, iStart wins and the beat is dropped.
  - Reset mid-window: everything cleared as above; no oDone.
- N_FEAT/LANES=1: ACCUM accepts a single beat, then goes straight to DRAIN.

Decomposition:
- Package svm_pkg holds:
  - state enum (IDLE, ACCUM, DRAIN, DONE);
  - PIPE_LAT=4;
  - clog2 helper function;
  - derived BEATS = N_FEAT/LANES and CNT_W = clog2(BEATS).
- Sub-module svm_adder_tree, parametrised by LANES, IN_W and OUT_W:
  - registered sum of LANES signed inputs;
  - carries the valid bit and a synchronous flush input.
- Top level holds the FSM, counter, S1 multipliers, accumulator and output registers.

Test Plan:
All scenarios use DATA_W=16, FRAC_W=8, LANES=2, N_FEAT=4, ACC_W=48; 1.0 = 0x0100 and -1.0 = 0xFF00.
- Basic positive: iBias=0; 2 beats of feat={1.0,1.0}, weight={1.0,1.0}, back-to-back -> oDone 4 edges after beat 2; oScore=0x0_0004_0000; oHuman=1.
- Negative with bias: weights all -1.0, features all 1.0, iBias=0x0_0001_0000 -> oScore=-3.0 (0xFFFF_FFFD_0000); oHuman=0.
- Zero boundary: features 0, iBias=0 -> oScore=0, oHuman=1. Extremes feat=0x8000, weight=0x8000 on all lanes -> oScore=4*2^30=0x1_0000_0000, no overflow.
- Gaps and ignored beats:
  - iValid asserted in IDLE before iStart -> ignored;
  - 3 idle cycles between the two beats -> same result as scenario 1; oDone timing relative to the last beat unchanged.
- Abort: iStart, one beat of {1.0,1.0}, then iStart again with iBias=0, then 2 beats of {1.0,1.0} -> exactly one oDone, with oScore=4.0.
- Reset mid-window: iRst_n=0 for 1 cycle after the first beat -> all outputs 0, no oDone; a following complete window gives the correct result.
